pe_net_interface: RTL and testbench
===================================

PE_NET_INTERFACE -- requirements
Module: pe_net_interface

Interface
REQ-001 The block SHALL have parameter DataWidth, default 36, meaning network flit width in bits.
REQ-002 The block SHALL have parameter AddrWidth, default 4, meaning destination field width occupying flit bits [DataWidth-1 -: AddrWidth].
REQ-003 The block SHALL have parameter MyAddr, default 0, meaning this PE's network address.
REQ-004 The block SHALL have parameter FifoDepth, default 4, meaning transmit FIFO entries (power of two, >=2).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: i_sclk input 1 (clock, all state on rising edge); i_reset input 1 (asynchronous, active-low reset).
REQ-006 The block SHALL have the PE transmit ports: i_pe_data input DataWidth-AddrWidth (payload); i_pe_dest input AddrWidth (destination); i_pe_valid input 1; o_pe_ready output 1.
REQ-007 The block SHALL have the network output ports: o_net_data output DataWidth; o_net_data_valid output 1; i_net_data_ready input 1.
REQ-008 The block SHALL have the network input ports: i_net_data input DataWidth; i_net_data_valid input 1; o_net_data_ready output 1.
REQ-009 The block SHALL have the PE receive ports: o_pe_data output DataWidth-AddrWidth; o_pe_data_valid output 1; i_pe_data_ready input 1.
REQ-010 The block SHALL have the status outputs: o_tx_count output 16 (flits sent); o_rx_count output 16 (flits delivered); o_drop_count output 8 (flits dropped).

Function
REQ-011 The block SHALL perform a transfer on any valid/ready pair only at a rising edge where both are 1.
REQ-012 The block SHALL keep each producer's valid and data stable until the transfer completes.
REQ-013 The block SHALL perform a TX push when i_pe_valid and o_pe_ready; the pushed flit is {i_pe_dest, i_pe_data}.
REQ-014 The block SHALL drive o_pe_ready = ~tx_full, based on registered occupancy only; a PE push is refused while full even if a pop occurs in the same cycle.
REQ-015 The block SHALL drive o_net_data and o_net_data_valid from the FIFO head; a pushed flit is visible at the earliest one cycle after acceptance.
REQ-016 The block SHALL perform a TX pop when o_net_data_valid and i_net_data_ready.
REQ-017 The block SHALL apply a simultaneous push and pop with the FIFO non-empty and non-full; occupancy is unchanged and order is preserved.
REQ-018 The block SHALL use wrapping read/write pointers of log2(FifoDepth) bits plus an occupancy counter of log2(FifoDepth)+1 bits.
REQ-019 The block SHALL implement the RX path as a 2-entry skid buffer with o_net_data_ready = ~rx_full (registered).
REQ-020 The block SHALL deliver an accepted RX flit with dest == MyAddr to o_pe_data (dest field stripped) one cycle after acceptance when the buffer is empty.
REQ-021 The block SHALL drop an accepted RX flit with dest != MyAddr without writing it to the buffer, and increment o_drop_count.
REQ-022 The block SHALL allow an RX accept and a PE-side pop in the same cycle, including when the buffer holds 1 entry.
REQ-023 The block SHALL increment o_tx_count on each TX pop, o_rx_count on each PE-side RX pop, and o_drop_count per REQ-021; all counters saturate at all-ones and never wrap.
REQ-024 The block SHALL leave TX and RX paths fully independent; neither stalls the other.

Reset
REQ-025 The block SHALL, while i_reset = 0 and asynchronously on its assertion, clear all pointers, occupancies, and counters; o_net_data_valid = 0, o_pe_data_valid = 0, o_pe_ready = 1, o_net_data_ready = 1, and o_net_data and o_pe_data = 0.
REQ-026 The block SHALL discard all FIFO contents when reset is asserted mid-transfer; no flit is emitted after deassertion until a new push.
REQ-027 The block SHALL first accept a transfer on the first rising edge after i_reset deasserts.

Verification
REQ-028 The bench SHALL cover TX in order: with MyAddr = 0, push payloads 1,2,3,4 to dest 5 with i_net_data_ready = 0 -> o_pe_ready = 0 after the 4th; raise ready -> o_net_data = {4'h5, payload} in order 1..4, then o_tx_count = 4.
REQ-029 The bench SHALL cover full boundary: with the FIFO full, pop and push in the same cycle -> the push is refused, occupancy = 3, and o_pe_ready = 1 the next cycle.
REQ-030 The bench SHALL cover RX filter: send flits with dest 0, 7, 0 -> o_pe_data delivers two flits, o_drop_count = 1, and o_rx_count = 2 after both are popped.
REQ-031 The bench SHALL cover RX backpressure: hold i_pe_data_ready = 0 while sending 3 flits with dest 0 -> o_net_data_ready = 0 after the 2nd accept and the 3rd is held; release -> all 3 are delivered in order.
REQ-032 The bench SHALL cover saturation: force 65537 TX pops -> o_tx_count = 16'hFFFF.
REQ-033 The bench SHALL cover reset mid-operation: assert i_reset with 2 TX and 1 RX flits buffered -> valids = 0 immediately and counters = 0; after release, no stale flits appear.

Source files
------------

// File: rtl/pe_net_interface_if.sv
// Handshake bundle between pe_net_interface and its PE and network neighbours.
// Signal names are written from the interface block's point of view.
interface pe_net_interface_if #(
   parameter int DataWidth = 36,
   parameter int AddrWidth = 4
);
   // PE transmit side
   logic [DataWidth-AddrWidth-1:0] i_pe_data;
   logic [AddrWidth-1:0]           i_pe_dest;
   logic                           i_pe_valid;
   logic                           o_pe_ready;
   // Network output side
   logic [DataWidth-1:0]           o_net_data;
   logic                           o_net_data_valid;
   logic                           i_net_data_ready;
   // Network input side
   logic [DataWidth-1:0]           i_net_data;
   logic                           i_net_data_valid;
   logic                           o_net_data_ready;
   // PE receive side
   logic [DataWidth-AddrWidth-1:0] o_pe_data;
   logic                           o_pe_data_valid;
   logic                           i_pe_data_ready;
   // Status
   logic [15:0]                    o_tx_count;
   logic [15:0]                    o_rx_count;
   logic [7:0]                     o_drop_count;

   // Every valid/ready pair transfers on a rising edge where both are high;
   // the producer holds valid and data stable until that edge.
   modport slave (
      input  i_pe_data, i_pe_dest, i_pe_valid, i_net_data_ready,
      input  i_net_data, i_net_data_valid, i_pe_data_ready,
      output o_pe_ready, o_net_data, o_net_data_valid, o_net_data_ready,
      output o_pe_data, o_pe_data_valid, o_tx_count, o_rx_count, o_drop_count
   );

   modport master (
      output i_pe_data, i_pe_dest, i_pe_valid, i_net_data_ready,
      output i_net_data, i_net_data_valid, i_pe_data_ready,
      input  o_pe_ready, o_net_data, o_net_data_valid, o_net_data_ready,
      input  o_pe_data, o_pe_data_valid, o_tx_count, o_rx_count, o_drop_count
   );
endinterface

// File: rtl/pe_net_interface.sv
// PE network interface: a TX FIFO toward the network, and an address-filtering
// 2-entry RX skid buffer toward the PE, with saturating traffic counters.
module pe_net_interface #(
   parameter int DataWidth = 36,
   parameter int AddrWidth = 4,
   parameter int MyAddr    = 0,
   parameter int FifoDepth = 4
) (
   input logic               i_sclk,
   input logic               i_reset,
   pe_net_interface_if.slave bus
);
   localparam int PtrW = $clog2(FifoDepth);
   localparam int PayW = DataWidth - AddrWidth;
   localparam logic [PtrW:0]        TxDepth = FifoDepth[PtrW:0];
   localparam logic [AddrWidth-1:0] MyAddrV = MyAddr[AddrWidth-1:0];

   logic [DataWidth-1:0] tx_mem_q [FifoDepth];
   logic [PtrW-1:0]      tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [PtrW:0]        tx_cnt_q, tx_cnt_d;
   logic                 tx_full, tx_empty, tx_push, tx_pop;

   logic [PayW-1:0]      rx_mem_q [2];
   logic                 rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [1:0]           rx_cnt_q, rx_cnt_d;
   logic                 rx_full, rx_empty, rx_accept, rx_hit, rx_write, rx_drop, rx_pop;

   logic [15:0]          tx_count_q, rx_count_q;
   logic [7:0]           drop_count_q;

   // Readiness comes from registered occupancy only, so a full FIFO refuses a
   // push even in a cycle where it also pops.
   assign tx_full  = (tx_cnt_q == TxDepth);
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_push  = bus.i_pe_valid & ~tx_full;
   assign tx_pop   = ~tx_empty & bus.i_net_data_ready;

   assign rx_full   = (rx_cnt_q == 2'd2);
   assign rx_empty  = (rx_cnt_q == 2'd0);
   assign rx_accept = bus.i_net_data_valid & ~rx_full;
   assign rx_hit    = (bus.i_net_data[DataWidth-1 -: AddrWidth] == MyAddrV);
   assign rx_write  = rx_accept & rx_hit;
   assign rx_drop   = rx_accept & ~rx_hit;
   assign rx_pop    = ~rx_empty & bus.i_pe_data_ready;

   always_comb begin
      tx_wr_d  = tx_push ? tx_wr_q + 1'b1 : tx_wr_q;
      tx_rd_d  = tx_pop ? tx_rd_q + 1'b1 : tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      case ({tx_push, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
         2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
         default: tx_cnt_d = tx_cnt_q;
      endcase
      rx_wr_d  = rx_wr_q ^ rx_write;
      rx_rd_d  = rx_rd_q ^ rx_pop;
      rx_cnt_d = rx_cnt_q;
      case ({rx_write, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
         2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
         default: rx_cnt_d = rx_cnt_q;
      endcase
   end

   // Storage needs no reset: outputs are gated by occupancy.
   always_ff @(posedge i_sclk) begin
      if (tx_push) tx_mem_q[tx_wr_q] <= {bus.i_pe_dest, bus.i_pe_data};
      if (rx_write) rx_mem_q[rx_wr_q] <= bus.i_net_data[PayW-1:0];
   end

   always_ff @(posedge i_sclk or negedge i_reset) begin
      if (!i_reset) begin
         tx_wr_q      <= '0;
         tx_rd_q      <= '0;
         tx_cnt_q     <= '0;
         rx_wr_q      <= 1'b0;
         rx_rd_q      <= 1'b0;
         rx_cnt_q     <= '0;
         tx_count_q   <= '0;
         rx_count_q   <= '0;
         drop_count_q <= '0;
      end else begin
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         rx_cnt_q <= rx_cnt_d;
         if (tx_pop && tx_count_q != '1) tx_count_q <= tx_count_q + 1'b1;
         if (rx_pop && rx_count_q != '1) rx_count_q <= rx_count_q + 1'b1;
         if (rx_drop && drop_count_q != '1) drop_count_q <= drop_count_q + 1'b1;
      end
   end

   assign bus.o_pe_ready       = ~tx_full;
   assign bus.o_net_data_valid = ~tx_empty;
   assign bus.o_net_data       = tx_empty ? '0 : tx_mem_q[tx_rd_q];
   assign bus.o_net_data_ready = ~rx_full;
   assign bus.o_pe_data_valid  = ~rx_empty;
   assign bus.o_pe_data        = rx_empty ? '0 : rx_mem_q[rx_rd_q];
   assign bus.o_tx_count       = tx_count_q;
   assign bus.o_rx_count       = rx_count_q;
   assign bus.o_drop_count     = drop_count_q;
endmodule

// File: tb/tb_pe_net_interface.sv
// Bench for pe_net_interface: directed scenarios plus a randomized phase, with
// expected flits queued at acceptance and checked by independent monitors.
module tb_pe_net_interface;
   localparam int DW = 36;
   localparam int AW = 4;
   localparam int PW = DW - AW;
   localparam int MY = 0;
   localparam int FD = 4;
   localparam int TMO = 2000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pe_net_interface_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

   pe_net_interface #(
      .DataWidth(DW), .AddrWidth(AW), .MyAddr(MY), .FifoDepth(FD)
   ) dut (
      .i_sclk (clk),
      .i_reset(rst_n),
      .bus    (bus)
   );

   logic [DW-1:0] tx_exp_q [$];
   logic [PW-1:0] rx_exp_q [$];
   int n_tests = 0;
   int n_fail = 0;
   int tx_sent = 0;
   int rx_deliv = 0;
   int rx_drop = 0;
   bit tx_done, rx_done;

   function automatic logic [15:0] sat16(input int n);
      return (n > 65535) ? 16'hFFFF : 16'(n);
   endfunction

   function automatic logic [7:0] sat8(input int n);
      return (n > 255) ? 8'hFF : 8'(n);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Drivers: called at posedge+1, return at posedge+1 after the transfer edge.
   task automatic tx_send(input logic [AW-1:0] dest, input logic [PW-1:0] pay);
      bit done = 0;
      bus.i_pe_dest  = dest;
      bus.i_pe_data  = pay;
      bus.i_pe_valid = 1'b1;
      for (int t = 0; t < TMO && !done; t++) begin
         @(negedge clk);
         if (bus.o_pe_ready) begin
            tx_exp_q.push_back({dest, pay});
            tx_sent++;
            done = 1;
         end
      end
      if (!done) fail_now("tx_send_timeout");
      @(posedge clk); #1;
      bus.i_pe_valid = 1'b0;
   endtask

   task automatic rx_send(input logic [AW-1:0] dest, input logic [PW-1:0] pay);
      bit done = 0;
      bus.i_net_data       = {dest, pay};
      bus.i_net_data_valid = 1'b1;
      for (int t = 0; t < TMO && !done; t++) begin
         @(negedge clk);
         if (bus.o_net_data_ready) begin
            if (dest == AW'(MY)) begin
               rx_exp_q.push_back(pay);
               rx_deliv++;
            end else begin
               rx_drop++;
            end
            done = 1;
         end
      end
      if (!done) fail_now("rx_send_timeout");
      @(posedge clk); #1;
      bus.i_net_data_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < TMO && (tx_exp_q.size() != 0 || rx_exp_q.size() != 0); t++)
         @(posedge clk);
      @(negedge clk);
      check("drain_tx_q", 64'(tx_exp_q.size()), 64'd0);
      check("drain_rx_q", 64'(rx_exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   // Monitors: a transfer is due at the next posedge when valid and ready are high.
   task automatic mon_tx();
      forever begin
         @(negedge clk);
         if (rst_n && bus.o_net_data_valid && bus.i_net_data_ready) begin
            if (tx_exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL tx_unexpected got=%0h expected=none", bus.o_net_data);
            end else begin
               check("tx_data", 64'(bus.o_net_data), 64'(tx_exp_q.pop_front()));
            end
         end
      end
   endtask

   task automatic mon_rx();
      forever begin
         @(negedge clk);
         if (rst_n && bus.o_pe_data_valid && bus.i_pe_data_ready) begin
            if (rx_exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rx_unexpected got=%0h expected=none", bus.o_pe_data);
            end else begin
               check("rx_data", 64'(bus.o_pe_data), 64'(rx_exp_q.pop_front()));
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_net_valid"}, 64'(bus.o_net_data_valid), 64'd0);
      check({tag, "_pe_valid"}, 64'(bus.o_pe_data_valid), 64'd0);
      check({tag, "_pe_ready"}, 64'(bus.o_pe_ready), 64'd1);
      check({tag, "_net_ready"}, 64'(bus.o_net_data_ready), 64'd1);
      check({tag, "_net_data"}, 64'(bus.o_net_data), 64'd0);
      check({tag, "_pe_data"}, 64'(bus.o_pe_data), 64'd0);
      check({tag, "_tx_count"}, 64'(bus.o_tx_count), 64'd0);
      check({tag, "_rx_count"}, 64'(bus.o_rx_count), 64'd0);
      check({tag, "_drop_count"}, 64'(bus.o_drop_count), 64'd0);
   endtask

   initial begin
      logic [PW-1:0] pa, pb, pc, pf;
      logic [AW-1:0] df;
      bus.i_pe_data        = '0;
      bus.i_pe_dest        = '0;
      bus.i_pe_valid       = 1'b0;
      bus.i_net_data_ready = 1'b0;
      bus.i_net_data       = '0;
      bus.i_net_data_valid = 1'b0;
      bus.i_pe_data_ready  = 1'b0;
      fork
         mon_tx();
         mon_rx();
         begin
            #5_000_000;
            $display("FAIL watchdog_timeout");
            n_fail++;
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $fatal(1, "watchdog");
         end
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // TX in order under backpressure
      for (int i = 1; i <= 4; i++) tx_send(4'h5, PW'(i));
      @(negedge clk);
      check("tx_ready_low_when_full", 64'(bus.o_pe_ready), 64'd0);
      check("tx_head_first", 64'(bus.o_net_data), {28'd0, 4'h5, 32'd1});
      @(posedge clk); #1;
      bus.i_net_data_ready = 1'b1;
      wait_drain();
      check("tx_count_4", 64'(bus.o_tx_count), 64'd4);

      // Full boundary: simultaneous pop and push while full
      bus.i_net_data_ready = 1'b0;
      for (int i = 0; i < 4; i++) tx_send(AW'($urandom_range(0, 15)), PW'($urandom));
      pf = PW'($urandom);
      df = AW'($urandom_range(0, 15));
      bus.i_net_data_ready = 1'b1;
      bus.i_pe_dest  = df;
      bus.i_pe_data  = pf;
      bus.i_pe_valid = 1'b1;
      @(negedge clk);
      check("full_push_refused", 64'(bus.o_pe_ready), 64'd0);
      @(posedge clk); #1;
      bus.i_net_data_ready = 1'b0;
      @(negedge clk);
      check("ready_after_pop", 64'(bus.o_pe_ready), 64'd1);
      if (bus.o_pe_ready) begin
         tx_exp_q.push_back({df, pf});
         tx_sent++;
      end
      @(posedge clk); #1;
      bus.i_pe_valid = 1'b0;
      @(negedge clk);
      check("refilled_from_three", 64'(bus.o_pe_ready), 64'd0);
      @(posedge clk); #1;
      bus.i_net_data_ready = 1'b1;
      wait_drain();
      check("tx_count_9", 64'(bus.o_tx_count), 64'(sat16(tx_sent)));

      // RX filter
      bus.i_pe_data_ready = 1'b1;
      rx_send(4'h0, PW'($urandom));
      rx_send(4'h7, PW'($urandom));
      rx_send(4'h0, PW'($urandom));
      wait_drain();
      check("rx_drop_1", 64'(bus.o_drop_count), 64'd1);
      check("rx_count_2", 64'(bus.o_rx_count), 64'd2);

      // RX backpressure
      bus.i_pe_data_ready = 1'b0;
      pa = PW'($urandom);
      pb = PW'($urandom);
      pc = PW'($urandom);
      rx_send(4'h0, pa);
      rx_send(4'h0, pb);
      @(negedge clk);
      check("rx_ready_low_full", 64'(bus.o_net_data_ready), 64'd0);
      @(posedge clk); #1;
      fork
         rx_send(4'h0, pc);
         begin
            repeat (3) @(negedge clk);
            check("rx_third_held_ready", 64'(bus.o_net_data_ready), 64'd0);
            check("rx_third_not_taken", 64'(rx_exp_q.size()), 64'd2);
            check("rx_head_held", 64'(bus.o_pe_data), 64'(pa));
            @(posedge clk); #1;
            bus.i_pe_data_ready = 1'b1;
         end
      join
      wait_drain();
      check("rx_count_5", 64'(bus.o_rx_count), 64'(rx_deliv));
      check("rx_drop_still_1", 64'(bus.o_drop_count), 64'(sat8(rx_drop)));

      // TX counter saturation
      bus.i_net_data_ready = 1'b1;
      for (int i = 0; i < 65537; i++) tx_send(AW'($urandom_range(0, 15)), PW'($urandom));
      wait_drain();
      check("tx_count_saturated", 64'(bus.o_tx_count), 64'hFFFF);

      // Reset mid-operation with 2 TX and 1 RX flits buffered
      bus.i_net_data_ready = 1'b0;
      bus.i_pe_data_ready  = 1'b0;
      tx_send(AW'($urandom_range(0, 15)), PW'($urandom));
      tx_send(AW'($urandom_range(0, 15)), PW'($urandom));
      rx_send(4'h0, PW'($urandom));
      @(negedge clk);
      check("pre_reset_tx_valid", 64'(bus.o_net_data_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      tx_exp_q.delete();
      rx_exp_q.delete();
      tx_sent = 0;
      rx_deliv = 0;
      rx_drop = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.i_net_data_ready = 1'b1;
      bus.i_pe_data_ready  = 1'b1;
      repeat (6) @(negedge clk);
      check("no_stale_tx", 64'(bus.o_net_data_valid), 64'd0);
      check("no_stale_rx", 64'(bus.o_pe_data_valid), 64'd0);
      @(posedge clk); #1;

      // Randomized concurrent traffic with random backpressure
      tx_done = 0;
      rx_done = 0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               tx_send(AW'($urandom_range(0, 15)), PW'($urandom));
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            tx_done = 1;
         end
         begin
            for (int i = 0; i < 60; i++) begin
               logic [AW-1:0] d;
               d = ($urandom_range(0, 1) == 1) ? AW'(MY) : AW'($urandom_range(1, 15));
               rx_send(d, PW'($urandom));
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            rx_done = 1;
         end
         begin
            while (!(tx_done && rx_done)) begin
               @(posedge clk); #1;
               bus.i_net_data_ready = 1'($urandom_range(0, 1));
               bus.i_pe_data_ready  = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.i_net_data_ready = 1'b1;
      bus.i_pe_data_ready  = 1'b1;
      wait_drain();
      check("rand_tx_count", 64'(bus.o_tx_count), 64'(sat16(tx_sent)));
      check("rand_rx_count", 64'(bus.o_rx_count), 64'(sat16(rx_deliv)));
      check("rand_drop_count", 64'(bus.o_drop_count), 64'(sat8(rx_drop)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
